vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Pixel-scan timing generator and colour output stage for the VGA path.
//  Drives counter_H/counter_V into the frame buffer, takes back the colour the
//  frame buffer returns for that pixel, and emits aligned hsync/vsync/RGB to the pins.
//  Sits between FrameBuffer_Top and the top-level uo_out/uio_out pins.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  SYNC_POL  0    sync active level (0 = active-low)
//  FB_LAT    1    frame-buffer latency, counter presented -> colour_in valid (cycles, >=0)
//  COL_W     6    colour width (RRGGBB)
// PORTS
//  clk          in   1      pixel-domain clock
//  rst_n        in   1      asynchronous active-low reset
//  pix_en       in   1      pixel strobe; all state advances only when high (tie 1 for 1 px/clk)
//  colour_in    in   COL_W  colour from frame buffer, valid FB_LAT cycles after counters
//  counter_H    out  10     horizontal position being requested, 0..H_TOTAL-1
//  counter_V    out  10     vertical position being requested, 0..V_TOTAL-1
//  hsync        out  1      horizontal sync, aligned with rgb_out
//  vsync        out  1      vertical sync, aligned with rgb_out
//  rgb_out      out  COL_W  registered pixel colour, zero outside the active area
//  display_on   out  1      high while rgb_out carries a visible pixel
//  frame_start  out  1      one-pix_en pulse when pixel (0,0) reaches rgb_out
//  frame_count  out  8      frames completed, wraps 255 -> 0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Reset (async assert, sync release): counters 0; hsync/vsync = !SYNC_POL;
//    rgb_out, display_on, frame_start, frame_count and all delay stages 0.
//  - With pix_en=1 each clk: counter_H+1; at H_TOTAL-1 -> 0 and counter_V+1;
//    at (H_TOTAL-1, V_TOTAL-1) both -> 0. pix_en=0: everything holds, pulses included.
//  - First pixel after reset release is (0,0); counter_H/V come straight from the counter flops.
//  - Raw hsync = SYNC_POL when H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
//  - Raw vsync = SYNC_POL when V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
//  - Raw active = (H < H_ACTIVE) && (V < V_ACTIVE).
//  - Alignment: raw hsync/vsync/active/first-pixel flags are delayed FB_LAT stages
//    (advanced by pix_en), then registered together with colour_in; total latency
//    from counter value to pins = FB_LAT+1 pix_en cycles for every output.
//  - rgb_out = delayed_active ? colour_in : 0; display_on = delayed_active.
//  - frame_start asserted for exactly one pix_en cycle; frame_count increments on
//    the same cycle frame_start asserts (not for the first frame after reset).
//  - Reset mid-frame: outputs return to reset values immediately; scan restarts at (0,0),
//    no partial sync pulse is extended.
//  - Counter widths fixed at 10 bits; parameters must satisfy H_TOTAL, V_TOTAL <= 1024.
// STRUCTURE
//  - Package vga_timing_pkg: default 640x480@60 timing constants, H_TOTAL/V_TOTAL,
//    sync window bounds, COL_W default.
//  - Sub-module vga_axis_counter (MAX, 10-bit, enable in, wrap pulse out),
//    instantiated twice: H (enable = pix_en) and V (enable = H wrap).
//  - Delay line: generic shift register of FB_LAT stages, width 4 (hs, vs, active, first).
// TESTING
//  - Reset, pix_en=1, FB_LAT=1: counter_H 0,1,2..; hsync first low when counter_H=658
//    (656+2), low for exactly 96 cycles.
//  - Full frame: counter_V wraps 524->0 after 420000 cycles; vsync low for 1600
//    consecutive cycles; frame_count 0->1 at second frame_start.
//  - colour_in=6'h3F constant: rgb_out=3F for 640 cycles per visible line, 0 for 160;
//    all 0 during lines 480..524.
//  - pix_en toggled 1/0: counters, sync, rgb_out hold on 0 cycles; line period = 1600 clk.
//  - Assert rst_n low at (H=700,V=490): hsync/vsync go high asynchronously, rgb_out=0;
//    after release scan restarts at (0,0).
//  - FB_LAT=3: colour_in = counter_H[5:0] delayed 3 -> rgb_out on pixel x equals x[5:0],
//    and hsync/display_on edges shift by exactly 4 cycles from counter values.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 scan timing, shared flag bundle and window helper for the
// VGA timing generator.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HS_LO    = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_HI    = DEF_HS_LO + DEF_H_SYNC - 1;
    localparam int DEF_VS_LO    = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_HI    = DEF_VS_LO + DEF_V_SYNC - 1;

    localparam int DEF_COL_W    = 6;

    // Polarity-free flags: hs/vs mean "inside the sync window".
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic first;
    } scan_flags_t;

    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Frame-buffer link: the timing generator requests a pixel position, the
// frame buffer returns its colour a fixed number of pixel strobes later.
interface vga_timing_gen_if #(parameter int COL_W = 6);

    // No back-pressure: counters change on every pix_en, and colour_in must
    // carry the colour for a position exactly FB_LAT pix_en cycles after it.
    logic [9:0]       counter_H;
    logic [9:0]       counter_V;
    logic [COL_W-1:0] colour_in;

    modport master (output counter_H, output counter_V, input colour_in);
    modport slave  (input counter_H, input counter_V, output colour_in);

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: counts 0..MAX on enable and pulses wrap on the MAX->0 step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = DEF_H_TOTAL - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wrap    = en && (count_q == CNT_W'(MAX));
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-scan timing generator: drives scan position to the frame buffer and
// re-aligns sync/active flags with the returned colour before the pins.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int FB_LAT   = 1,
    parameter int COL_W    = DEF_COL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    vga_timing_gen_if.master  fb,
    output logic              hsync,
    output logic              vsync,
    output logic [COL_W-1:0]  rgb_out,
    output logic              display_on,
    output logic              frame_start,
    output logic [7:0]        frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC - 1;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC - 1;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;

    vga_axis_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    assign fb.counter_H = h_cnt;
    assign fb.counter_V = v_cnt;

    scan_flags_t raw_flags, dly_flags;

    always_comb begin
        raw_flags.hs     = in_window(h_cnt, HS_LO, HS_HI);
        raw_flags.vs     = in_window(v_cnt, VS_LO, VS_HI);
        raw_flags.active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        raw_flags.first  = (h_cnt == '0) && (v_cnt == '0);
    end

    // Flags ride alongside the frame-buffer read so they meet colour_in.
    if (FB_LAT == 0) begin : g_no_dly
        assign dly_flags = raw_flags;
    end else begin : g_dly
        scan_flags_t stage_q [FB_LAT];
        scan_flags_t stage_d [FB_LAT];

        always_comb begin
            for (int i = 0; i < FB_LAT; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (pix_en) begin
                stage_d[0] = raw_flags;
                for (int i = 1; i < FB_LAT; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < FB_LAT; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dly_flags = stage_q[FB_LAT-1];
    end

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [COL_W-1:0] rgb_q, rgb_d;
    logic             display_on_q, display_on_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             seen_wrap_q, seen_wrap_d;

    // seen_wrap keeps the first frame after reset from being counted.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        display_on_d  = display_on_q;
        frame_start_d = frame_start_q;
        frame_count_d = frame_count_q;
        seen_wrap_d   = seen_wrap_q | v_wrap;
        if (pix_en) begin
            hsync_d       = dly_flags.hs ? SYNC_POL : ~SYNC_POL;
            vsync_d       = dly_flags.vs ? SYNC_POL : ~SYNC_POL;
            rgb_d         = dly_flags.active ? fb.colour_in : '0;
            display_on_d  = dly_flags.active;
            frame_start_d = dly_flags.first;
            if (dly_flags.first && seen_wrap_q) begin
                frame_count_d = frame_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            rgb_q         <= '0;
            display_on_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            seen_wrap_q   <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            display_on_q  <= display_on_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            seen_wrap_q   <= seen_wrap_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_out     = rgb_q;
    assign display_on  = display_on_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
